// File: rtl/load_store_unit.sv
// Load/store unit: one request at a time toward a word-only data memory,
// with sign/zero-extending sub-word loads and read-modify-write sub-word stores.
module load_store_unit #(
    parameter bit CHECK_ALIGN = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic [31:0] rdata,
    output logic        misaligned,
    output logic        MemRead,
    output logic        MemWrite,
    output logic [31:0] endereco,
    output logic [31:0] dado_in,
    input  logic [31:0] dado_out
);

    localparam logic [2:0] OP_LB  = 3'b000;
    localparam logic [2:0] OP_LH  = 3'b001;
    localparam logic [2:0] OP_LW  = 3'b010;
    localparam logic [2:0] OP_SB  = 3'b011;
    localparam logic [2:0] OP_LBU = 3'b100;
    localparam logic [2:0] OP_LHU = 3'b101;
    localparam logic [2:0] OP_SH  = 3'b110;
    localparam logic [2:0] OP_SW  = 3'b111;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RD   = 3'd1,
        S_MRG  = 3'd2,
        S_WR   = 3'd3,
        S_RESP = 3'd4,
        S_ERR  = 3'd5
    } state_t;

    state_t      state_r;
    state_t      state_s;
    logic [2:0]  op_r;
    logic [31:0] addr_r;
    logic [31:0] wdata_r;
    logic [31:0] word_r;
    logic [31:0] rdata_r;

    function automatic logic is_load(input logic [2:0] o);
        return (o != OP_SB) && (o != OP_SH) && (o != OP_SW);
    endfunction

    function automatic logic is_misaligned(input logic [2:0] o, input logic [1:0] a);
        logic m;
        case (o)
            OP_LW, OP_SW:         m = (a != 2'b00);
            OP_LH, OP_LHU, OP_SH: m = a[0];
            default:              m = 1'b0;
        endcase
        return m;
    endfunction

    // Little-endian lane select followed by sign or zero extension.
    function automatic logic [31:0] extract(input logic [2:0] o, input logic [1:0] a,
                                            input logic [31:0] w);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = w[{a, 3'b000} +: 8];
        h = a[1] ? w[31:16] : w[15:0];
        case (o)
            OP_LB:   r = {{24{b[7]}}, b};
            OP_LBU:  r = {24'h000000, b};
            OP_LH:   r = {{16{h[15]}}, h};
            OP_LHU:  r = {16'h0000, h};
            default: r = w;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] merge(input logic [2:0] o, input logic [1:0] a,
                                          input logic [31:0] w, input logic [31:0] d);
        logic [31:0] r;
        r = w;
        case (o)
            OP_SB: r[{a, 3'b000} +: 8] = d[7:0];
            OP_SH: begin
                if (a[1]) begin
                    r[31:16] = d[15:0];
                end else begin
                    r[15:0] = d[15:0];
                end
            end
            default: r = d;
        endcase
        return r;
    endfunction

    // Next-state decode.
    always_comb begin
        state_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (start) begin
                    if (CHECK_ALIGN && is_misaligned(op, addr[1:0])) begin
                        state_s = S_ERR;
                    end else if (op == OP_SW) begin
                        state_s = S_WR;
                    end else begin
                        state_s = S_RD;
                    end
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_RD: begin
                if (is_load(op_r)) begin
                    state_s = S_RESP;
                end else begin
                    state_s = S_MRG;
                end
            end
            S_MRG:   state_s = S_RESP;
            S_WR:    state_s = S_RESP;
            S_RESP:  state_s = S_IDLE;
            S_ERR:   state_s = S_IDLE;
            default: state_s = S_IDLE;
        endcase
    end

    // State, request latches, read word and load result.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= S_IDLE;
            op_r    <= 3'b000;
            addr_r  <= 32'h0000_0000;
            wdata_r <= 32'h0000_0000;
            word_r  <= 32'h0000_0000;
            rdata_r <= 32'h0000_0000;
        end else begin
            state_r <= state_s;
            if (state_r == S_IDLE && start) begin
                op_r    <= op;
                addr_r  <= addr;
                wdata_r <= wdata;
            end
            if (state_r == S_RD) begin
                word_r <= dado_out;
                if (is_load(op_r)) begin
                    rdata_r <= extract(op_r, addr_r[1:0], dado_out);
                end
            end
        end
    end

    // Strobes are gated with reset so nothing commits on a reset edge.
    always_comb begin
        busy       = (state_r != S_IDLE);
        done       = (state_r == S_RESP) || (state_r == S_ERR);
        misaligned = (state_r == S_ERR);
        MemRead    = (state_r == S_RD) && !reset;
        MemWrite   = ((state_r == S_MRG) || (state_r == S_WR)) && !reset;
        rdata      = rdata_r;
        if (state_r == S_RD || state_r == S_MRG || state_r == S_WR) begin
            endereco = {addr_r[31:2], 2'b00};
        end else begin
            endereco = 32'h0000_0000;
        end
        if (state_r == S_MRG) begin
            dado_in = merge(op_r, addr_r[1:0], word_r, wdata_r);
        end else if (state_r == S_WR) begin
            dado_in = wdata_r;
        end else begin
            dado_in = 32'h0000_0000;
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench: two units (strict and forced alignment) share stimulus, each
// with its own word memory model; expectations are hand-computed.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        reset, start;
    logic [2:0]  op;
    logic [31:0] addr, wdata;

    logic        busy, done, misaligned, mem_read, mem_write;
    logic [31:0] rdata, endereco, dado_in, dado_out;
    logic        busy_b, done_b, misaligned_b, mem_read_b, mem_write_b;
    logic [31:0] rdata_b, endereco_b, dado_in_b, dado_out_b;

    logic        mem_init;
    logic [31:0] mem_a [0:15];
    logic [31:0] mem_b [0:15];
    int          done_a_cnt = 0, done_b_cnt = 0, mis_b_cnt = 0;
    int          tests = 0, fails = 0;

    always #5 clk = ~clk;

    load_store_unit #(.CHECK_ALIGN(1'b1)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .addr(addr), .wdata(wdata),
        .busy(busy), .done(done), .rdata(rdata), .misaligned(misaligned),
        .MemRead(mem_read), .MemWrite(mem_write), .endereco(endereco),
        .dado_in(dado_in), .dado_out(dado_out)
    );

    load_store_unit #(.CHECK_ALIGN(1'b0)) dut_b (
        .clk(clk), .reset(reset), .start(start), .op(op), .addr(addr), .wdata(wdata),
        .busy(busy_b), .done(done_b), .rdata(rdata_b), .misaligned(misaligned_b),
        .MemRead(mem_read_b), .MemWrite(mem_write_b), .endereco(endereco_b),
        .dado_in(dado_in_b), .dado_out(dado_out_b)
    );

    assign dado_out   = (endereco[1:0] != 2'b00)   ? 32'h0 : mem_a[endereco[5:2]];
    assign dado_out_b = (endereco_b[1:0] != 2'b00) ? 32'h0 : mem_b[endereco_b[5:2]];

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 16; i++) begin
                mem_a[i] <= 32'h0;
                mem_b[i] <= 32'h0;
            end
            mem_a[4] <= 32'h8899AABB;
            mem_b[4] <= 32'h8899AABB;
        end else begin
            if (mem_write)   mem_a[endereco[5:2]]   <= dado_in;
            if (mem_write_b) mem_b[endereco_b[5:2]] <= dado_in_b;
        end
        if (done)         done_a_cnt <= done_a_cnt + 1;
        if (done_b)       done_b_cnt <= done_b_cnt + 1;
        if (misaligned_b) mis_b_cnt  <= mis_b_cnt + 1;
    end

    // Issue one request; report cycles (relative to acceptance) of first MemRead,
    // first MemWrite and done (-1 if not seen), plus write data and misaligned.
    task automatic do_req(input logic [2:0] o, input logic [31:0] a, input logic [31:0] w,
                          output int dc, output int rc, output int wc,
                          output logic [31:0] wd, output logic mis);
        dc = -1; rc = -1; wc = -1; wd = 32'h0; mis = 1'b0;
        @(negedge clk);
        start = 1'b1; op = o; addr = a; wdata = w;
        @(negedge clk);
        start = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            if (mem_read && rc < 0) rc = c;
            if (mem_write && wc < 0) begin
                wc = c;
                wd = dado_in;
            end
            if (done) begin
                dc  = c;
                mis = misaligned;
                break;
            end
            @(negedge clk);
        end
        for (int g = 0; g < 8 && (busy || busy_b); g++) @(negedge clk);
    endtask

    task automatic test_reset();
        tests++;
        if ({busy, done, misaligned, mem_read, mem_write} !== 5'b00000) begin
            fails++;
            $display("FAIL reset_flags: got %b expected 00000",
                     {busy, done, misaligned, mem_read, mem_write});
        end
        tests++;
        if (rdata !== 32'h0) begin
            fails++; $display("FAIL reset_rdata: got %h expected 00000000", rdata);
        end
        tests++;
        if (endereco !== 32'h0 || dado_in !== 32'h0) begin
            fails++;
            $display("FAIL reset_bus: endereco %h dado_in %h expected 0/0", endereco, dado_in);
        end
    endtask

    task automatic test_loads();
        logic [2:0]  ops [4] = '{3'b000, 3'b100, 3'b101, 3'b001};
        logic [31:0] ads [4] = '{32'h11, 32'h13, 32'h10, 32'h12};
        logic [31:0] exp [4] = '{32'hFFFFFFAA, 32'h00000088, 32'h0000AABB, 32'hFFFF8899};
        int dc, rc, wc; logic [31:0] wd; logic mis;
        for (int i = 0; i < 4; i++) begin
            do_req(ops[i], ads[i], 32'h0, dc, rc, wc, wd, mis);
            tests++;
            if (rdata !== exp[i]) begin
                fails++; $display("FAIL load_%0d_rdata: got %h expected %h", i, rdata, exp[i]);
            end
            tests++;
            if (dc !== 2 || rc !== 1 || wc !== -1) begin
                fails++;
                $display("FAIL load_%0d_timing: done %0d rd %0d wr %0d expected 2/1/-1",
                         i, dc, rc, wc);
            end
        end
    endtask

    task automatic test_sb_merge();
        int dc, rc, wc; logic [31:0] wd; logic mis;
        do_req(3'b011, 32'h12, 32'h12345655, dc, rc, wc, wd, mis);
        tests++;
        if (rc !== 1 || wc !== 2 || dc !== 3) begin
            fails++;
            $display("FAIL sb_timing: rd %0d wr %0d done %0d expected 1/2/3", rc, wc, dc);
        end
        tests++;
        if (wd !== 32'h8855AABB) begin
            fails++; $display("FAIL sb_dado_in: got %h expected 8855aabb", wd);
        end
        do_req(3'b010, 32'h10, 32'h0, dc, rc, wc, wd, mis);
        tests++;
        if (rdata !== 32'h8855AABB || dc !== 2) begin
            fails++;
            $display("FAIL sb_readback: got %h done %0d expected 8855aabb/2", rdata, dc);
        end
    endtask

    task automatic test_sw_sh();
        int dc, rc, wc; logic [31:0] wd; logic mis;
        do_req(3'b111, 32'h14, 32'hDEADBEEF, dc, rc, wc, wd, mis);
        tests++;
        if (dc !== 2 || wc !== 1 || rc !== -1 || wd !== 32'hDEADBEEF) begin
            fails++;
            $display("FAIL sw: done %0d wr %0d rd %0d data %h expected 2/1/-1/deadbeef",
                     dc, wc, rc, wd);
        end
        do_req(3'b110, 32'h16, 32'h0000CAFE, dc, rc, wc, wd, mis);
        tests++;
        if (dc !== 3 || wd !== 32'hCAFEBEEF) begin
            fails++;
            $display("FAIL sh: done %0d data %h expected 3/cafebeef", dc, wd);
        end
        tests++;
        if (rdata !== 32'h8855AABB) begin
            fails++; $display("FAIL store_rdata_hold: got %h expected 8855aabb", rdata);
        end
        do_req(3'b010, 32'h14, 32'h0, dc, rc, wc, wd, mis);
        tests++;
        if (rdata !== 32'hCAFEBEEF) begin
            fails++; $display("FAIL sw_sh_readback: got %h expected cafebeef", rdata);
        end
    endtask

    task automatic test_misaligned();
        int dc, rc, wc; logic [31:0] wd; logic mis; int b0;
        b0 = done_b_cnt;
        do_req(3'b010, 32'h16, 32'h0, dc, rc, wc, wd, mis);
        tests++;
        if (dc !== 1 || mis !== 1'b1 || rc !== -1 || wc !== -1) begin
            fails++;
            $display("FAIL mis_lw: done %0d mis %b rd %0d wr %0d expected 1/1/-1/-1",
                     dc, mis, rc, wc);
        end
        tests++;
        if (rdata !== 32'hCAFEBEEF) begin
            fails++; $display("FAIL mis_rdata_hold: got %h expected cafebeef", rdata);
        end
        tests++;
        if (rdata_b !== 32'hCAFEBEEF || done_b_cnt - b0 !== 1) begin
            fails++;
            $display("FAIL noalign_lw: got %h dones %0d expected cafebeef/1",
                     rdata_b, done_b_cnt - b0);
        end
        do_req(3'b001, 32'h11, 32'h0, dc, rc, wc, wd, mis);
        tests++;
        if (dc !== 1 || mis !== 1'b1 || rdata !== 32'hCAFEBEEF) begin
            fails++;
            $display("FAIL mis_lh: done %0d mis %b rdata %h expected 1/1/cafebeef",
                     dc, mis, rdata);
        end
        tests++;
        if (rdata_b !== 32'hFFFFAABB || mis_b_cnt !== 0) begin
            fails++;
            $display("FAIL noalign_lh: got %h mis %0d expected ffffaabb/0", rdata_b, mis_b_cnt);
        end
    endtask

    task automatic test_reset_mrg();
        int a0, b0;
        @(negedge clk);
        start = 1'b1; op = 3'b011; addr = 32'h10; wdata = 32'h00000077;
        @(negedge clk);
        start = 1'b0;
        a0 = done_a_cnt; b0 = done_b_cnt;
        @(negedge clk);
        tests++;
        if (mem_write !== 1'b1) begin
            fails++; $display("FAIL rst_mrg_precheck: MemWrite %b expected 1", mem_write);
        end
        reset = 1'b1;
        #1;
        tests++;
        if (mem_write !== 1'b0 || mem_write_b !== 1'b0) begin
            fails++;
            $display("FAIL rst_mrg_gate: MemWrite %b/%b expected 0/0", mem_write, mem_write_b);
        end
        @(negedge clk);
        reset = 1'b0;
        tests++;
        if (busy !== 1'b0 || busy_b !== 1'b0) begin
            fails++; $display("FAIL rst_mrg_busy: got %b/%b expected 0/0", busy, busy_b);
        end
        repeat (3) @(negedge clk);
        tests++;
        if (done_a_cnt !== a0 || done_b_cnt !== b0) begin
            fails++;
            $display("FAIL rst_mrg_done: extra dones %0d/%0d expected 0/0",
                     done_a_cnt - a0, done_b_cnt - b0);
        end
        tests++;
        if (mem_a[4] !== 32'h8855AABB || mem_b[4] !== 32'h8855AABB) begin
            fails++;
            $display("FAIL rst_mrg_mem: got %h/%h expected 8855aabb", mem_a[4], mem_b[4]);
        end
    endtask

    task automatic test_start_held();
        logic [8:0] mask;
        mask = 9'b0;
        @(negedge clk);
        start = 1'b1; op = 3'b010; addr = 32'h10; wdata = 32'h0;
        for (int c = 0; c < 9; c++) begin
            if (done) mask[c] = 1'b1;
            @(negedge clk);
        end
        start = 1'b0;
        tests++;
        if (mask !== 9'b100100100) begin
            fails++; $display("FAIL held_spacing: done mask %b expected 100100100", mask);
        end
        tests++;
        if (rdata !== 32'h8855AABB) begin
            fails++; $display("FAIL held_rdata: got %h expected 8855aabb", rdata);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_start_ignored();
        int n_done, n_wr, dcyc;
        n_done = 0; n_wr = 0; dcyc = -1;
        @(negedge clk);
        start = 1'b1; op = 3'b010; addr = 32'h10; wdata = 32'h0;
        @(negedge clk);
        op = 3'b111; addr = 32'h14; wdata = 32'hFFFFFFFF;
        for (int c = 1; c <= 7; c++) begin
            if (c == 3) start = 1'b0;
            if (done) begin
                n_done++;
                dcyc = c;
            end
            if (mem_write) n_wr++;
            @(negedge clk);
        end
        tests++;
        if (n_done !== 1 || dcyc !== 2 || n_wr !== 0) begin
            fails++;
            $display("FAIL busy_start_ignored: dones %0d at %0d writes %0d expected 1/2/0",
                     n_done, dcyc, n_wr);
        end
        tests++;
        if (mem_a[5] !== 32'hCAFEBEEF) begin
            fails++; $display("FAIL busy_start_mem: got %h expected cafebeef", mem_a[5]);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; start = 1'b0; op = 3'b000; addr = 32'h0; wdata = 32'h0;
        mem_init = 1'b1;
        repeat (2) @(negedge clk);
        mem_init = 1'b0;
        test_reset();
        reset = 1'b0;
        test_loads();
        test_sb_merge();
        test_sw_sh();
        test_misaligned();
        test_reset_mrg();
        test_start_held();
        test_start_ignored();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
